user_module_nibble_rx: RTL and testbench

//  Serial nibble receiver: far end of the shift-out link of our counter/shift-register tiles.

---
 rtl/nibble_link_pkg.sv | 19 +
 rtl/link_sync.sv | 40 ++++
 rtl/user_module_nibble_rx.sv | 173 +++++++++++++++++
 tb/tb_user_module_nibble_rx.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/nibble_link_pkg.sv
// rtl/nibble_link_pkg.sv - shared types and helpers for the serial nibble link
package nibble_link_pkg;

    localparam int DATA_W_C      = 4;
    localparam int SYNC_STAGES_C = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        PARITY   = 2'd2,
        WAIT_END = 2'd3
    } rx_state_e;

    // Even-parity bit for a data nibble; the transmitter appends exactly this value.
    function automatic logic even_parity(input logic [DATA_W_C-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/link_sync.sv
// rtl/link_sync.sv - multi-flop synchroniser with rising-edge detect on the strobe line
module link_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rise
);

    // Strobe and companion lines share one chain so they emerge on the same cycle.
    logic [STAGES-1:0][WIDTH:0] sync_q;
    logic [STAGES-1:0][WIDTH:0] sync_d;
    logic                       prev_q;
    logic                       prev_d;
    logic                       strobe_s;

    always_comb begin
        sync_d   = {sync_q[STAGES-2:0], {d, strobe_in}};
        strobe_s = sync_q[STAGES-1][0];
        prev_d   = strobe_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[STAGES-1][WIDTH:1];
    assign rise = strobe_s & ~prev_q;

endmodule

// File: rtl/user_module_nibble_rx.sv
// rtl/user_module_nibble_rx.sv - framed serial nibble receiver; RX_PARITY_EN adds an even-parity bit
module user_module_nibble_rx
    import nibble_link_pkg::*;
#(
    parameter int DATA_W      = DATA_W_C,
    parameter int SYNC_STAGES = SYNC_STAGES_C
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic clk;
    logic rst;
    logic err_clr;
    logic unused_pins;

    assign clk         = io_in[0];
    assign rst         = io_in[1];
    assign err_clr     = io_in[5];
    assign unused_pins = ^io_in[7:6];

    logic [1:0] sync_bus;
    logic       frame_s;
    logic       sdata_s;
    logic       bit_ev;

    link_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (2)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .strobe_in (io_in[3]),
        .d         ({io_in[2], io_in[4]}),
        .q         (sync_bus),
        .rise      (bit_ev)
    );

    assign frame_s = sync_bus[0];
    assign sdata_s = sync_bus[1];

    rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  sh_q, sh_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               frame_err_q, frame_err_d;
    logic               par_err_q;
`ifdef RX_PARITY_EN
    logic               par_err_d;
`endif

    logic [DATA_W-1:0]  sh_next;
    logic               last_bit;

    assign sh_next  = {sh_q[DATA_W-2:0], sdata_s};
    assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = frame_err_q;
`ifdef RX_PARITY_EN
        par_err_d   = par_err_q;
`endif

        // Clear first so that a same-cycle error set below takes precedence.
        if (err_clr) begin
            frame_err_d = 1'b0;
`ifdef RX_PARITY_EN
            par_err_d   = 1'b0;
`endif
        end

        case (state_q)
            IDLE: begin
                if (frame_s) begin
                    cnt_d   = '0;
                    sh_d    = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_ev) begin
                    sh_d  = sh_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_bit) begin
`ifdef RX_PARITY_EN
                        state_d    = PARITY;
`else
                        rx_data_d  = sh_next;
                        rx_valid_d = 1'b1;
                        state_d    = WAIT_END;
`endif
                    end
                end else if (!frame_s) begin
                    frame_err_d = 1'b1;
                    sh_d        = '0;
                    state_d     = IDLE;
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (bit_ev) begin
                    if (sdata_s == even_parity(sh_q)) begin
                        rx_data_d  = sh_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        par_err_d  = 1'b1;
                    end
                    state_d = WAIT_END;
                end else if (!frame_s) begin
                    frame_err_d = 1'b1;
                    sh_d        = '0;
                    state_d     = IDLE;
                end
            end
`endif
            WAIT_END: begin
                if (bit_ev) begin
                    frame_err_d = 1'b1;
                end
                if (!frame_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
`else
    assign par_err_q = 1'b0;
`endif

    logic busy;
    assign busy = (state_q != IDLE);

    assign io_out = {busy, par_err_q, frame_err_q, rx_valid_q, rx_data_q[3:0]};

endmodule

// File: tb/tb_user_module_nibble_rx.sv
// tb/tb_user_module_nibble_rx.sv - directed bench for user_module_nibble_rx
module tb_user_module_nibble_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sdata;
    logic       sclk;
    logic       frame;
    logic       err_clr;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int errors    = 0;
    int checks    = 0;
    int valid_cnt = 0;
    int v0;

    always #5 clk = ~clk;

    assign io_in = {2'b00, err_clr, frame, sclk, sdata, rst, clk};

    user_module_nibble_rx dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always @(negedge clk) begin
        if (io_out[4] === 1'b1) valid_cnt++;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        sdata = b;
        #50;
        sclk = 1'b1;
        #50;
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [4:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        #10;
        err_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sdata = 1'b0; sclk = 1'b0; frame = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_io_out", io_out, 8'h00);
        check("reset_busy", {7'd0, io_out[7]}, 8'h00);
        rst = 1'b0;

        // sclk activity with frame low is ignored
        send_bits(5'b00111, 3);
        #50;
        check("idle_io_out", io_out, 8'h00);
        check("idle_valid", 8'(valid_cnt), 8'd0);

        // 1,0,1,1 -> 4'hB, then busy falls one cycle after synced frame low
        v0 = valid_cnt;
        frame = 1'b1; #100;
        send_bits(5'b01011, 4);
        check("b_data", {4'h0, io_out[3:0]}, 8'h0B);
        check("b_valid", 8'(valid_cnt - v0), 8'd1);
        check("b_busy_wait", {7'd0, io_out[7]}, 8'h01);
        frame = 1'b0;
        #20;
        check("b_busy_hold", {7'd0, io_out[7]}, 8'h01);
        #10;
        check("b_busy_drop", {7'd0, io_out[7]}, 8'h00);
        check("b_frame_err", {7'd0, io_out[5]}, 8'h00);
        #50;

        // short frame after two bits
        v0 = valid_cnt;
        frame = 1'b1; #100;
        send_bits(5'b00010, 2);
        frame = 1'b0; #50;
        check("short_frame_err", {7'd0, io_out[5]}, 8'h01);
        check("short_data_kept", {4'h0, io_out[3:0]}, 8'h0B);
        check("short_no_valid", 8'(valid_cnt - v0), 8'd0);
        check("short_busy", {7'd0, io_out[7]}, 8'h00);
        pulse_clr();
        check("short_err_clr", {7'd0, io_out[5]}, 8'h00);
        #50;

        // back-to-back 3 then 6 with a 5-clock gap
        v0 = valid_cnt;
        frame = 1'b1; #100;
        send_bits(5'b00011, 4);
        check("b2b_first", {4'h0, io_out[3:0]}, 8'h03);
        frame = 1'b0; #50;
        frame = 1'b1; #100;
        send_bits(5'b00110, 4);
        check("b2b_second", {4'h0, io_out[3:0]}, 8'h06);
        check("b2b_valids", 8'(valid_cnt - v0), 8'd2);
        frame = 1'b0; #100;

        // five bits: valid 4'hA then frame_err on the extra bit
        v0 = valid_cnt;
        frame = 1'b1; #100;
        send_bits(5'b10101, 5);
        frame = 1'b0; #50;
        check("extra_data", {4'h0, io_out[3:0]}, 8'h0A);
        check("extra_valid", 8'(valid_cnt - v0), 8'd1);
        check("extra_frame_err", {7'd0, io_out[5]}, 8'h01);
        pulse_clr();
        check("extra_err_clr", {7'd0, io_out[5]}, 8'h00);
        #50;

        // frame falls together with the final sclk rise: bit wins
        v0 = valid_cnt;
        frame = 1'b1; #100;
        send_bits(5'b00010, 3);
        sdata = 1'b1; #50;
        sclk = 1'b1; frame = 1'b0; #50;
        sclk = 1'b0; #50;
        check("tie_data", {4'h0, io_out[3:0]}, 8'h05);
        check("tie_valid", 8'(valid_cnt - v0), 8'd1);
        check("tie_frame_err", {7'd0, io_out[5]}, 8'h00);
        check("tie_busy", {7'd0, io_out[7]}, 8'h00);

`ifdef RX_PARITY_EN
        v0 = valid_cnt;
        frame = 1'b1; #100;
        send_bits(5'b01111, 5);
        frame = 1'b0; #50;
        check("par_good_data", {4'h0, io_out[3:0]}, 8'h07);
        check("par_good_valid", 8'(valid_cnt - v0), 8'd1);
        check("par_good_err", {6'd0, io_out[6:5]}, 8'h00);
        v0 = valid_cnt;
        frame = 1'b1; #100;
        send_bits(5'b01110, 5);
        frame = 1'b0; #50;
        check("par_bad_err", {7'd0, io_out[6]}, 8'h01);
        check("par_bad_data", {4'h0, io_out[3:0]}, 8'h07);
        check("par_bad_no_valid", 8'(valid_cnt - v0), 8'd0);
        pulse_clr();
        check("par_err_clr", {7'd0, io_out[6]}, 8'h00);
`else
        v0 = valid_cnt;
        frame = 1'b1; #100;
        send_bits(5'b01111, 5);
        frame = 1'b0; #50;
        check("nopar_data", {4'h0, io_out[3:0]}, 8'h07);
        check("nopar_valid", 8'(valid_cnt - v0), 8'd1);
        check("nopar_frame_err", {7'd0, io_out[5]}, 8'h01);
        check("nopar_par_err", {7'd0, io_out[6]}, 8'h00);
        pulse_clr();
`endif
        #50;

        // reset mid-frame abandons the frame and clears all outputs
        v0 = valid_cnt;
        frame = 1'b1; #100;
        send_bits(5'b00011, 2);
        rst = 1'b1; #20;
        check("midrst_io_out", io_out, 8'h00);
        frame = 1'b0; #20;
        rst = 1'b0; #50;
        check("midrst_after", io_out, 8'h00);
        check("midrst_no_valid", 8'(valid_cnt - v0), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
